// File: rtl/identifier_fsm.sv
// Streaming recognizer: out is high while the character stream so far
// ends in one or more letters followed by one or more digits.
module identifier_fsm (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] char,
  output logic       out
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LET  = 2'b01,
    DIG  = 2'b10
  } state_t;

  state_t state;
  logic   is_let;
  logic   is_dig;

  always_comb begin
    is_let = ((char >= 8'h41) && (char <= 8'h5A)) ||
             ((char >= 8'h61) && (char <= 8'h7A));
    is_dig = (char >= 8'h30) && (char <= 8'h39);
  end

  // A digit only advances from a letter run or an existing digit run;
  // the spare 2'b11 encoding falls through to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    state <= is_let ? LET : IDLE;
        LET:     state <= is_let ? LET : (is_dig ? DIG : IDLE);
        DIG:     state <= is_dig ? DIG : (is_let ? LET : IDLE);
        default: state <= IDLE;
      endcase
    end
  end

  assign out = (state == DIG);

endmodule

// File: tb/tb_identifier_fsm.sv
// Self-checking bench for identifier_fsm: directed vector table, corner
// sequences around reset, and random characters against a history model.
module tb_identifier_fsm;

  logic       clk;
  logic       rst_n;
  logic [7:0] char;
  logic       out;

  int checks;
  int errors;

  typedef struct packed {
    logic [7:0] c;
    logic       e;
  } vec_t;

  vec_t       tbl[$];
  logic [7:0] hist[$];

  identifier_fsm dut (
    .clk   (clk),
    .rst_n (rst_n),
    .char  (char),
    .out   (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit is_let(input logic [7:0] c);
    return (c >= "A" && c <= "Z") || (c >= "a" && c <= "z");
  endfunction

  function automatic bit is_dig(input logic [7:0] c);
    return c >= "0" && c <= "9";
  endfunction

  // Stream ends in letter+ digit+ iff there is a non-empty trailing digit
  // run and the character just before it is a letter.
  function automatic bit model_out();
    int i;
    int nd;
    i  = hist.size() - 1;
    nd = 0;
    while (i >= 0 && is_dig(hist[i])) begin
      nd++;
      i--;
    end
    return (nd > 0) && (i >= 0) && is_let(hist[i]);
  endfunction

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: out=%b expected=%b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic [7:0] c);
    @(negedge clk);
    char = c;
    hist.push_back(c);
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic [7:0] c, input logic e);
    tbl.push_back({c, e});
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    hist.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    char   = "a";

    // Directed table; entries run back to back after one reset.
    add("a", 0); add("b", 0); add("c", 0); add("d", 0);
    add("1", 1); add("2", 1); add("3", 1); add("4", 1); add("/", 0);
    add("1", 0); add("2", 0); add("x", 0); add("9", 1);
    add("q", 0); add("7", 1); add("Z", 0); add("8", 1);
    add("A", 0); add("0", 1);
    add("z", 0); add("9", 1);
    add("@", 0); add("0", 0);
    add("[", 0); add("0", 0);
    add(8'h60, 0); add("0", 0);
    add("a", 0); add(":", 0);
    add("a", 0); add(8'hB1, 0);
    add("a", 0); add("b", 0); add("1", 1); add("2", 1); add("c", 0); add("3", 1);
    add(8'h00, 0); add("5", 0);

    // Held in reset with a letter on char and the clock running.
    #1;
    check("reset_async", out, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("reset_hold", out, 1'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset_release", out, 1'b0);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].c);
      check($sformatf("vec%0d", i), out, tbl[i].e);
    end

    // Asynchronous reset in the middle of a token.
    do_reset();
    step("x");
    check("mid_x", out, 1'b0);
    step("5");
    check("mid_5", out, 1'b1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    hist.delete();
    #1;
    check("mid_async_drop", out, 1'b0);
    #1;
    rst_n = 1'b1;
    step("6");
    check("mid_after_6", out, 1'b0);

    // Random stream biased toward letters and digits.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      logic [7:0] c;
      case ($urandom_range(0, 4))
        0: c = 8'($urandom_range(65, 90));
        1: c = 8'($urandom_range(97, 122));
        2, 3: c = 8'($urandom_range(48, 57));
        default: c = 8'($urandom_range(0, 255));
      endcase
      step(c);
      check($sformatf("rand%0d_c%02h", i, c), out, model_out());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/identifier_fsm.md
# identifier_fsm

Streaming recognizer for identifier-like tokens. It consumes one 8-bit ASCII character per clock and asserts `out` while the sequence received so far ends in one or more letters followed by one or more digits, for example `abcd1234`. It sits after a character source, such as a UART RX byte path or a test stimulus, as a lexical flag generator. The RTL module name is `identifier_fsm`.

## Interface
Parameters: none.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  input  1  clock; all state updates on the rising edge.
- `rst_n`  input  1  asynchronous active-low reset.
- `char`  input  8  ASCII character, one per cycle, sampled on each rising `clk`.
- `out`  output  1  high while the accepted stream ends in letter+ digit+.

## Operation
Character classes, combinational on `char`:
- LETTER: 8'h41–8'h5A (`A`–`Z`) or 8'h61–8'h7A (`a`–`z`).
- DIGIT: 8'h30–8'h39 (`0`–`9`).
- OTHER: every remaining code, including 8'h00, 8'h2F (`/`), 8'h3A (`:`), 8'h40 (`@`), 8'h5B, 8'h60, 8'h7B and anything ≥ 8'h80.

States (Moore, 2-bit encoding):
- IDLE: no letter run in progress.
- LET: the last character was a letter.
- DIG: one or more digits directly follow a letter run.

Transitions, one per rising `clk` edge:
- IDLE: LETTER → LET; DIGIT → IDLE; OTHER → IDLE.
- LET: LETTER → LET; DIGIT → DIG; OTHER → IDLE.
- DIG: DIGIT → DIG; LETTER → LET; OTHER → IDLE.

Output and rules:
- `out` = (state == DIG). It is decoded from the state register only; there is no combinational path from `char` to `out`.
- A letter after digits restarts the letter run. After `ab12c`, `out` is 0; a following `3` sets it to 1 again.
- A digit while in IDLE never arms the FSM, so `12` alone leaves `out` at 0.
- Every input is a valid character. There is no idle or valid qualifier, so a 0x00 input counts as OTHER.
- The unused state encoding (2'b11) must go to IDLE on the next edge, and `out` must be 0 while in it.

## Timing
- Reset: `rst_n` = 0 immediately forces state to IDLE and `out` to 0, independent of `clk`.
- Reset release: the first sampling edge is the first rising `clk` with `rst_n` = 1.
- Reset mid-token: the token is discarded, and the stream restarts from IDLE.
- Latency: the character sampled at edge N is reflected on `out` right after edge N (one-cycle registered Moore output). `out` is stable for the whole following cycle.
- The source must hold `char` stable around each rising edge; it changes `char` on the falling edge.
- One character is consumed per cycle. There is no backpressure and no handshake.

## Test plan
- Reset: assert `rst_n` = 0 with `char` = `a` and the clock running → `out` = 0 and state = IDLE throughout. Release `rst_n` → `out` stays 0 until a digit follows a letter.
- Basic token: reset, then `a`,`b`,`c`,`d`,`1`,`2`,`3`,`4`,`/` (97,98,99,100,49,50,51,52,47) on successive edges → `out` = 0 after the four letters, 1 after each of `1`–`4`, and 0 after `/`.
- Digit first: `1`,`2`,`x`,`9` → `out` is 0, 0, 0, 1.
- Letter after digits: `q`,`7`,`Z`,`8` → `out` is 0, 1, 0, 1.
- Class boundaries:
  - `A`,`0` → `out` ends at 1.
  - `z`,`9` → `out` ends at 1.
  - `@`,`0` → `out` ends at 0.
  - `[`,`0` → `out` ends at 0.
  - `` ` ``,`0` → `out` ends at 0.
  - `a`,`:` → `out` ends at 0.
  - `a`,8'hB1 → `out` ends at 0.
- Async reset mid-token: `x`,`5` gives `out` = 1. Pulse `rst_n` low between clock edges → `out` drops to 0 immediately. Then `6` → `out` stays 0.
